// File: rtl/missile_pool_if.sv
// Launch handshake between enemy/boss fire logic (master) and the missile pool (slave).
interface missile_pool_if;
  logic       launch;
  logic [9:0] start_x;
  logic [9:0] start_y;
  logic       launch_ack;
  logic       launch_drop;

  modport master (output launch, start_x, start_y, input  launch_ack, launch_drop);
  modport slave  (input  launch, start_x, start_y, output launch_ack, launch_drop);
endinterface

// File: rtl/missile_pool.sv
// Pool of NUM_MSL falling missiles with one launch port and one pixel query.
// Optional feature: define MISSILE_DRAW_EXPLOSION_EN to draw exploding slots from a second ROM frame.
module missile_pool #(
  parameter int NUM_MSL     = 4,
  parameter int STEP_Y      = 5,
  parameter int GROUND_Y    = 400,
  parameter int SPR_W       = 8,
  parameter int SPR_H       = 20,
  parameter int EXPL_FRAMES = 16,
  parameter int ADDR_W      = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_clk,
  missile_pool_if.slave       lp,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  output logic                is_missle,
  output logic [ADDR_W-1:0]   addr,
  output logic [NUM_MSL-1:0]  busy_mask,
  output logic                explode,
  output logic [9:0]          expl_x
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FLY     = 2'd1,
    S_EXPLODE = 2'd2
  } slot_state_e;

  localparam int CNT_W = (EXPL_FRAMES > 1) ? $clog2(EXPL_FRAMES) : 1;
  localparam logic [10:0]       STEP_Y_W = 11'(STEP_Y);
  localparam logic [10:0]       GROUND_W = 11'(GROUND_Y);
  localparam logic [9:0]        GROUND_Y10 = 10'(GROUND_Y);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(EXPL_FRAMES - 1);
  localparam logic [9:0]        HALF_W   = 10'(SPR_W / 2);
  localparam logic [9:0]        HALF_H   = 10'(SPR_H / 2);
  localparam logic [9:0]        SPR_W_10 = 10'(SPR_W);
  localparam logic [9:0]        SPR_H_10 = 10'(SPR_H);
  localparam logic [ADDR_W-1:0] SPR_W_A  = ADDR_W'(SPR_W);
`ifdef MISSILE_DRAW_EXPLOSION_EN
  localparam logic [ADDR_W-1:0] FRAME_OFS = ADDR_W'(SPR_W * SPR_H);
`endif

  slot_state_e        state_q [NUM_MSL];
  slot_state_e        state_d [NUM_MSL];
  logic [9:0]         x_q     [NUM_MSL];
  logic [9:0]         x_d     [NUM_MSL];
  logic [9:0]         y_q     [NUM_MSL];
  logic [9:0]         y_d     [NUM_MSL];
  logic [CNT_W-1:0]   cnt_q   [NUM_MSL];
  logic [CNT_W-1:0]   cnt_d   [NUM_MSL];
  logic [10:0]        y_next  [NUM_MSL];

  logic               frame_clk_q, frame_clk_d;
  logic               tick_q, tick_d;
  logic               launch_ack_q, launch_ack_d;
  logic               launch_drop_q, launch_drop_d;
  logic               explode_q, explode_d;
  logic [9:0]         expl_x_q, expl_x_d;
  logic [NUM_MSL-1:0] busy_mask_q, busy_mask_d;

  logic [NUM_MSL-1:0] grant;
  logic               idle_seen;
  logic [NUM_MSL-1:0] enter_expl;

  logic [9:0]         dx     [NUM_MSL];
  logic [9:0]         dy     [NUM_MSL];
  logic [ADDR_W-1:0]  base   [NUM_MSL];
  logic [NUM_MSL-1:0] drawn;
  logic [NUM_MSL-1:0] hit;

  // Next-state logic: frame edge detect, lowest-idle allocation, per-slot FSMs, launch/explode status.
  always_comb begin
    frame_clk_d = frame_clk;
    tick_d      = frame_clk & ~frame_clk_q;

    // Eligibility uses registered state, so a slot freeing this cycle is not offered until next cycle.
    idle_seen = 1'b0;
    grant     = '0;
    for (int i = 0; i < NUM_MSL; i++) begin
      grant[i]  = (state_q[i] == S_IDLE) && !idle_seen;
      idle_seen = idle_seen | (state_q[i] == S_IDLE);
    end

    enter_expl = '0;
    for (int i = 0; i < NUM_MSL; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      cnt_d[i]   = cnt_q[i];
      y_next[i]  = {1'b0, y_q[i]} + STEP_Y_W;
      case (state_q[i])
        S_IDLE: begin
          if (lp.launch && grant[i]) begin
            state_d[i] = S_FLY;
            x_d[i]     = lp.start_x;
            y_d[i]     = lp.start_y;
          end else begin
            state_d[i] = S_IDLE;
          end
        end
        S_FLY: begin
          if (tick_q) begin
            if (y_next[i] >= GROUND_W) begin
              state_d[i]    = S_EXPLODE;
              y_d[i]        = GROUND_Y10;
              cnt_d[i]      = CNT_INIT;
              enter_expl[i] = 1'b1;
            end else begin
              y_d[i] = y_next[i][9:0];
            end
          end else begin
            state_d[i] = S_FLY;
          end
        end
        S_EXPLODE: begin
          if (tick_q) begin
            if (cnt_q[i] == '0) begin
              state_d[i] = S_IDLE;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end else begin
            state_d[i] = S_EXPLODE;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end

    launch_ack_d  = lp.launch & idle_seen;
    launch_drop_d = lp.launch & ~idle_seen;
    explode_d     = |enter_expl;
    expl_x_d      = expl_x_q;
    for (int i = NUM_MSL - 1; i >= 0; i--) begin
      expl_x_d = enter_expl[i] ? x_q[i] : expl_x_d;
    end
    for (int i = 0; i < NUM_MSL; i++) begin
      busy_mask_d[i] = (state_d[i] != S_IDLE);
    end
  end

  // State and status registers; Reset aborts every slot without an explode pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_clk_q   <= 1'b0;
      tick_q        <= 1'b0;
      launch_ack_q  <= 1'b0;
      launch_drop_q <= 1'b0;
      explode_q     <= 1'b0;
      expl_x_q      <= 10'd0;
      busy_mask_q   <= '0;
      for (int i = 0; i < NUM_MSL; i++) begin
        state_q[i] <= S_IDLE;
        x_q[i]     <= 10'd0;
        y_q[i]     <= 10'd0;
        cnt_q[i]   <= '0;
      end
    end else begin
      frame_clk_q   <= frame_clk_d;
      tick_q        <= tick_d;
      launch_ack_q  <= launch_ack_d;
      launch_drop_q <= launch_drop_d;
      explode_q     <= explode_d;
      expl_x_q      <= expl_x_d;
      busy_mask_q   <= busy_mask_d;
      for (int i = 0; i < NUM_MSL; i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Pixel query: sprite-relative offsets wrap mod 1024, lowest-index hitting slot supplies the address.
  always_comb begin
    is_missle = 1'b0;
    addr      = '0;
    for (int i = 0; i < NUM_MSL; i++) begin
      dx[i] = DrawX - x_q[i] + HALF_W;
      dy[i] = DrawY - y_q[i] + HALF_H;
`ifdef MISSILE_DRAW_EXPLOSION_EN
      drawn[i] = (state_q[i] == S_FLY) || (state_q[i] == S_EXPLODE);
      base[i]  = (state_q[i] == S_EXPLODE) ? FRAME_OFS : '0;
`else
      drawn[i] = (state_q[i] == S_FLY);
      base[i]  = '0;
`endif
      hit[i]    = drawn[i] && (dx[i] < SPR_W_10) && (dy[i] < SPR_H_10);
      addr      = (hit[i] && !is_missle)
                  ? (base[i] + ADDR_W'(dy[i]) * SPR_W_A + ADDR_W'(dx[i]))
                  : addr;
      is_missle = is_missle | hit[i];
    end
  end

  assign lp.launch_ack  = launch_ack_q;
  assign lp.launch_drop = launch_drop_q;
  assign explode        = explode_q;
  assign expl_x         = expl_x_q;
  assign busy_mask      = busy_mask_q;

endmodule

// File: tb/tb_missile_pool.sv
// Self-checking bench for missile_pool: directed sequences, a pixel table and a randomized run
// against a slot-level reference model.
module tb_missile_pool;
  localparam int NUM = 4, STEP = 5, GROUND = 400, SW = 8, SH = 20, EXPL = 16;
`ifdef MISSILE_DRAW_EXPLOSION_EN
  localparam bit DRAW_EXPL = 1'b1;
`else
  localparam bit DRAW_EXPL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_clk = 1'b0;
  logic [9:0]  DrawX = 10'd0, DrawY = 10'd0;
  logic        is_missle, explode;
  logic [15:0] addr;
  logic [3:0]  busy_mask;
  logic [9:0]  expl_x;

  missile_pool_if lp_if();

  missile_pool dut (
    .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .lp(lp_if),
    .DrawX(DrawX), .DrawY(DrawY), .is_missle(is_missle), .addr(addr),
    .busy_mask(busy_mask), .explode(explode), .expl_x(expl_x)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Reference model: a slot is busy; exploding while m_left>0 (ticks still to spend exploding).
  bit m_busy [NUM];
  int m_x [NUM], m_y [NUM], m_left [NUM];
  bit m_fc, m_tick, m_ack, m_drop, m_explode;
  int m_expl_x;

  bit obs_explode;
  logic [9:0] obs_x;

  typedef struct {
    logic [9:0]  px;
    logic [9:0]  py;
    logic        hit;
    logic [15:0] a;
  } pix_vec_t;
  pix_vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] m_mask();
    logic [3:0] m;
    for (int i = 0; i < NUM; i++) m[i] = m_busy[i];
    return m;
  endfunction

  task automatic model_pix(input int px, input int py, output bit h, output int a);
    h = 1'b0; a = 0;
    for (int i = 0; i < NUM; i++) begin
      int dxm, dym;
      dxm = (px - m_x[i] + SW / 2 + 1024) % 1024;
      dym = (py - m_y[i] + SH / 2 + 1024) % 1024;
      if (!h && m_busy[i] && (m_left[i] == 0 || DRAW_EXPL) && dxm < SW && dym < SH) begin
        h = 1'b1;
        a = dym * SW + dxm + ((m_left[i] > 0) ? SW * SH : 0);
      end
    end
  endtask

  task automatic model_step();
    int slot;
    bit tick_now, seen;
    if (rst) begin
      for (int i = 0; i < NUM; i++) begin
        m_busy[i] = 0; m_x[i] = 0; m_y[i] = 0; m_left[i] = 0;
      end
      m_fc = 0; m_tick = 0; m_ack = 0; m_drop = 0; m_explode = 0; m_expl_x = 0;
      return;
    end
    tick_now = m_tick; seen = 0; slot = -1;
    if (lp_if.launch)
      for (int i = 0; i < NUM; i++) if (!m_busy[i] && slot < 0) slot = i;
    if (tick_now)
      for (int i = 0; i < NUM; i++) if (m_busy[i]) begin
        if (m_left[i] > 0) begin
          m_left[i]--;
          if (m_left[i] == 0) m_busy[i] = 0;
        end else if (m_y[i] + STEP >= GROUND) begin
          m_y[i] = GROUND; m_left[i] = EXPL;
          if (!seen) m_expl_x = m_x[i];
          seen = 1;
        end else begin
          m_y[i] += STEP;
        end
      end
    m_explode = seen;
    m_ack = lp_if.launch && slot >= 0;
    m_drop = lp_if.launch && slot < 0;
    if (m_ack) begin
      m_busy[slot] = 1; m_x[slot] = lp_if.start_x; m_y[slot] = lp_if.start_y; m_left[slot] = 0;
    end
    m_tick = frame_clk && !m_fc;
    m_fc = frame_clk;
  endtask

  task automatic cycle();
    bit h; int a;
    @(posedge clk);
    model_step();
    #1;
    chk("busy_mask", busy_mask, m_mask());
    chk("launch_ack", lp_if.launch_ack, m_ack);
    chk("launch_drop", lp_if.launch_drop, m_drop);
    chk("explode", explode, m_explode);
    chk("expl_x", expl_x, m_expl_x);
    model_pix(DrawX, DrawY, h, a);
    chk("is_missle", is_missle, h);
    chk("addr", addr, a);
  endtask

  task automatic frame_tick();
    frame_clk = 1'b1; cycle(); cycle();
    obs_explode = explode; obs_x = expl_x;
    frame_clk = 1'b0; cycle();
  endtask

  task automatic do_launch(input int sx, input int sy);
    lp_if.launch = 1'b1; lp_if.start_x = 10'(sx); lp_if.start_y = 10'(sy);
    cycle();
    lp_if.launch = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
  endtask

  task automatic pix(input string name, input int px, input int py, input bit h, input int a);
    DrawX = 10'(px); DrawY = 10'(py); #1;
    chk({name, "_hit"}, is_missle, h);
    chk({name, "_addr"}, addr, a);
  endtask

  initial begin
    vecs[0] = '{10'd97,  10'd191, 1'b1, 16'd9};
    vecs[1] = '{10'd104, 10'd191, 1'b0, 16'd0};
    vecs[2] = '{10'd96,  10'd190, 1'b1, 16'd0};
    vecs[3] = '{10'd103, 10'd209, 1'b1, 16'd159};
    vecs[4] = '{10'd95,  10'd190, 1'b0, 16'd0};
    vecs[5] = '{10'd96,  10'd210, 1'b0, 16'd0};
    vecs[6] = '{10'd100, 10'd200, 1'b1, 16'd84};
    vecs[7] = '{10'd103, 10'd190, 1'b1, 16'd7};

    lp_if.launch = 1'b0; lp_if.start_x = 10'd0; lp_if.start_y = 10'd0;
    do_reset();
    chk("rst_busy", busy_mask, 4'd0);
    chk("rst_explode", explode, 1'b0);
    chk("rst_expl_x", expl_x, 10'd0);
    chk("rst_pix", is_missle, 1'b0);

    // Pixel table around a parked slot 0 at (100,200)
    do_launch(100, 200);
    chk("t4_ack", lp_if.launch_ack, 1'b1);
    for (int k = 0; k < 8; k++)
      pix($sformatf("t4_vec%0d", k), vecs[k].px, vecs[k].py, vecs[k].hit, vecs[k].a);

    // Fall from (100,50) to the ground in 70 ticks
    do_reset();
    do_launch(100, 50);
    chk("t1_ack", lp_if.launch_ack, 1'b1);
    cycle();
    chk("t1_ack_gone", lp_if.launch_ack, 1'b0);
    for (int k = 1; k <= 70; k++) begin
      frame_tick();
      if (k < 70) pix("t1_y", 100, 50 + 5 * k, 1'b1, 84);
      if (k == 69) chk("t1_no_explode", obs_explode, 1'b0);
    end
    chk("t1_explode", obs_explode, 1'b1);
    chk("t1_expl_x", obs_x, 10'd100);
    pix("t1_ground", 100, 400, DRAW_EXPL, DRAW_EXPL ? 244 : 0);

    // Five launches into four slots
    do_reset();
    lp_if.launch = 1'b1;
    for (int k = 0; k < 5; k++) begin
      lp_if.start_x = 10'(20 * k); lp_if.start_y = 10'd0;
      cycle();
      chk("t2_ack", lp_if.launch_ack, (k < 4) ? 1'b1 : 1'b0);
      chk("t2_drop", lp_if.launch_drop, (k == 4) ? 1'b1 : 1'b0);
    end
    lp_if.launch = 1'b0;
    chk("t2_busy", busy_mask, 4'b1111);

    // Explosion lifetime and reuse of the freed slot
    do_reset();
    do_launch(50, 400);
    for (int k = 1; k < 4; k++) do_launch(200 + k, 0);
    for (int k = 0; k < 16; k++) frame_tick();
    chk("t3_still_busy", busy_mask, 4'b1111);
    frame_clk = 1'b1; cycle();
    lp_if.launch = 1'b1; lp_if.start_x = 10'd77; lp_if.start_y = 10'd30;
    cycle();
    chk("t3_drop", lp_if.launch_drop, 1'b1);
    chk("t3_freed", busy_mask, 4'b1110);
    cycle();
    chk("t3_ack", lp_if.launch_ack, 1'b1);
    chk("t3_reused", busy_mask, 4'b1111);
    lp_if.launch = 1'b0; frame_clk = 1'b0; cycle();
    pix("t3_new_slot", 77, 30, 1'b1, 84);

    // Overlap priority, with slot 0 then exploding
    do_reset();
    do_launch(100, 396);
    do_launch(500, 100);
    do_launch(102, 394);
    pix("t5_fly", 100, 400, 1'b1, 116);
    frame_tick();
    pix("t5_expl", 100, 400, 1'b1, DRAW_EXPL ? 244 : 90);

    // Launch coincident with a tick, then reset mid-flight
    do_reset();
    frame_clk = 1'b1; cycle();
    do_launch(200, 123);
    frame_clk = 1'b0; cycle();
    pix("t6_no_move", 200, 123, 1'b1, 84);
    frame_tick();
    pix("t6_moved", 200, 128, 1'b1, 84);
    do_launch(300, 398);
    frame_clk = 1'b1; cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("t6_rst_busy", busy_mask, 4'd0);
    chk("t6_rst_explode", explode, 1'b0);
    frame_clk = 1'b0; cycle();
    chk("t6_rst_explode2", explode, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int s;
      rst = ($urandom_range(0, 399) == 0);
      lp_if.launch = ($urandom_range(0, 5) == 0);
      lp_if.start_x = 10'($urandom_range(0, 639));
      lp_if.start_y = 10'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 420));
      if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
      s = $urandom_range(0, NUM - 1);
      DrawX = 10'(m_x[s] + 1024 + int'($urandom_range(0, 14)) - 7);
      DrawY = 10'(m_y[s] + 1024 + int'($urandom_range(0, 26)) - 13);
      cycle();
    end
    rst = 1'b0; lp_if.launch = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
